// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Upstream stimulus stage for a JK flip-flop. It buffers JK opcodes in a small
// FIFO. Each opcode has a repeat count. When start is seen, the sequencer
// replays the queue cycle-accurately onto registered j/k outputs. These
// outputs connect directly to the flip-flop's J and K inputs.
//
// Opcode encoding {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
//
// Optional feature: define JK_SEQ_ABORT_EN to add the `abort` input.
//   - When aborted mid-replay, the next cycle drives one 01 (reset) pulse.
//   - The FIFO is flushed and the FSM returns to IDLE without a done pulse.
//   - In IDLE, abort only flushes the FIFO.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   cmd_valid   command offered this cycle
//   cmd_ready   FIFO can accept (registered, high while level < DEPTH)
//   cmd_op      {j,k} opcode of the offered command
//   cmd_rep     opcode is driven for cmd_rep+1 cycles
//   start       begin replay (honoured only in IDLE with a non-empty FIFO)
//   abort       (JK_SEQ_ABORT_EN only) cancel replay / flush queue
//   busy        high while in FETCH or DRIVE
//   done        one-cycle pulse when the queue has drained
//   fifo_level  number of stored entries
//   j, k        registered J/K drive
//
// Timing notes:
//   j/k and done are registered one cycle behind the state that produces
//   them. The first opcode therefore appears two cycles after start is
//   sampled. Back-to-back commands are separated by one 00 (hold) cycle,
//   which comes from the FETCH slot. The done pulse coincides with the 00
//   cycle that follows the last driven opcode.
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  input  logic             start,
`ifdef JK_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [LVL_W-1:0] fifo_level,
  output logic             j,
  output logic             k
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 2 + CNT_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             ready_r;

  // Sequencer state
  state_t           state_r;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             j_r;
  logic             k_r;
  logic             busy_r;
  logic             done_r;

  // Combinational helpers
  logic             abort_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] head_s;
  logic [LVL_W-1:0] level_next_s;

`ifdef JK_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign cmd_ready  = ready_r;
  assign fifo_level = level_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign j          = j_r;
  assign k          = k_r;

  // Push/pop qualification and the level after this edge (abort flushes to zero)
  always_comb begin
    push_s       = cmd_valid && ready_r && !abort_s;
    pop_s        = (state_r == ST_FETCH) && (level_r != LVL_ZERO) && !abort_s;
    head_s       = mem_r[rd_ptr_r];
    level_next_s = level_r;
    if (abort_s) begin
      level_next_s = LVL_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_next_s = level_r + LVL_W'(1);
        2'b01:   level_next_s = level_r - LVL_W'(1);
        default: level_next_s = level_r;
      endcase
    end
  end

  // Command FIFO: storage, wrapping pointers, level and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ready_r  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (abort_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {cmd_op, cmd_rep};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_next_s;
      ready_r <= (level_next_s != LVL_FULL);
    end
  end

  // Replay FSM with registered j/k, busy and done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      cnt_r   <= CNT_ZERO;
      j_r     <= 1'b0;
      k_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (abort_s && (state_r != ST_IDLE)) begin
      // A single reset pulse leaves the flip-flop in a known state after a cancelled replay
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      cnt_r   <= CNT_ZERO;
      j_r     <= 1'b0;
      k_r     <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      // Outputs trail the state by one cycle, so FETCH and DONE show as 00
      j_r    <= (state_r == ST_DRIVE) ? op_r[1] : 1'b0;
      k_r    <= (state_r == ST_DRIVE) ? op_r[0] : 1'b0;
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start && (level_r != LVL_ZERO) && !abort_s) begin
            state_r <= ST_FETCH;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          op_r    <= head_s[ENT_W-1 -: 2];
          cnt_r   <= head_s[CNT_W-1:0];
          state_r <= ST_DRIVE;
          busy_r  <= 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_r == CNT_ZERO) begin
            // A push landing on this same edge still counts toward continuing
            if (level_next_s != LVL_ZERO) begin
              state_r <= ST_FETCH;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= ST_DRIVE;
            busy_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for jk_cmd_sequencer.
//
// The reference model keeps the command queue as a SystemVerilog queue. For
// the command being played, it expands each command into a per-cycle list of
// drive slots. Every output is compared each cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cmd_ready;
  logic             busy;
  logic             done;
  logic [LVL_W-1:0] fifo_level;
  logic             j;
  logic             k;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LVL_W(LVL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .start     (start),
`ifdef JK_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .fifo_level(fifo_level),
    .j         (j),
    .k         (k)
  );

  // ---------------- reference model ----------------
  // Phase of the replay: 0 idle, 1 fetching a command, 2 driving, 3 finishing.
  int                 phase = 0;
  logic [1:0]         slot_op = 2'b00;
  logic [CNT_W+1:0]   queue_m[$];
  logic [1:0]         slots[$];
  logic               exp_j = 1'b0, exp_k = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;
  int                 exp_level = 0;

  task automatic model_step();
    int               pre;
    logic [1:0]       shown;
    logic [CNT_W+1:0] e;
    pre   = queue_m.size();
    shown = (phase == 2) ? slot_op : 2'b00;
    if (rst) begin
      queue_m.delete();
      slots.delete();
      phase = 0;
      {exp_j, exp_k} = 2'b00;
      exp_done = 1'b0;
    end else if (abort && phase != 0) begin
      queue_m.delete();
      slots.delete();
      phase = 0;
      {exp_j, exp_k} = 2'b01;
      exp_done = 1'b0;
    end else begin
      {exp_j, exp_k} = shown;
      exp_done = (phase == 3);
      if (abort) queue_m.delete();
      else if (cmd_valid && pre < DEPTH) queue_m.push_back({cmd_op, cmd_rep});
      case (phase)
        0: if (start && pre != 0 && !abort) phase = 1;
        1: begin
          e = queue_m.pop_front();
          for (int i = 0; i <= int'(e[CNT_W-1:0]); i++) slots.push_back(e[CNT_W+1:CNT_W]);
          slot_op = slots.pop_front();
          phase = 2;
        end
        2: begin
          if (slots.size() != 0) slot_op = slots.pop_front();
          else if (queue_m.size() != 0) phase = 1;
          else phase = 3;
        end
        default: phase = 0;
      endcase
    end
    exp_busy  = (phase == 1 || phase == 2);
    exp_level = queue_m.size();
    exp_ready = (queue_m.size() < DEPTH);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("j", 8'(j), 8'(exp_j));
    chk("k", 8'(k), 8'(exp_k));
    chk("done", 8'(done), 8'(exp_done));
    chk("busy", 8'(busy), 8'(exp_busy));
    chk("fifo_level", 8'(fifo_level), 8'(exp_level));
    chk("cmd_ready", 8'(cmd_ready), 8'(exp_ready));
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic [1:0] op,
                     input logic [CNT_W-1:0] rep, input logic ab);
    rst = r; start = s; cmd_valid = v; cmd_op = op; cmd_rep = rep; abort = ab;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b0);
  endtask

  task automatic push(input logic [1:0] op, input logic [CNT_W-1:0] rep);
    cyc(1'b0, 1'b0, 1'b1, op, rep, 1'b0);
  endtask

  task automatic go();
    cyc(1'b0, 1'b1, 1'b0, 2'b00, '0, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && phase != 0; n++) idle();
    chk("drain_busy", 8'(busy), 8'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int dones;
    int saw_start;

    // Reset held two cycles with a command offered: nothing gets stored
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd3, 1'b0);
    chk("rst_level", 8'(fifo_level), 8'(0));
    chk("rst_ready", 8'(cmd_ready), 8'(1));
    idle();

    // Single command (10, rep=2): three set cycles and one done pulse
    push(2'b10, 4'd2);
    go();
    cnt = 0; dones = 0;
    for (int n = 0; n < 8; n++) begin
      idle();
      if ({j, k} == 2'b10) cnt++;
      if (done) dones++;
    end
    chk("single_len", 8'(cnt), 8'(3));
    chk("single_done", 8'(dones), 8'(1));

    // Back-to-back commands
    push(2'b01, 4'd0);
    push(2'b11, 4'd1);
    push(2'b10, 4'd0);
    go();
    drain();
    idle();

    // Fill to full, refused fifth push, then push during DRIVE
    push(2'b10, 4'd1);
    push(2'b01, 4'd0);
    push(2'b11, 4'd2);
    push(2'b10, 4'd0);
    chk("full_ready", 8'(cmd_ready), 8'(0));
    push(2'b01, 4'd3);
    chk("full_level", 8'(fifo_level), 8'(4));
    go();
    idle();
    idle();
    push(2'b11, 4'd1);
    push(2'b01, 4'd2);
    drain();
    idle();

    // Start with an empty FIFO is ignored
    go();
    chk("empty_busy", 8'(busy), 8'(0));
    idle();
    chk("empty_done", 8'(done), 8'(0));

    // Maximum repeat count: exactly 2^CNT_W toggle cycles
    push(2'b11, 4'd15);
    go();
    cnt = 0;
    for (int n = 0; n < 24; n++) begin
      idle();
      if ({j, k} == 2'b11) cnt++;
    end
    chk("rep_max_len", 8'(cnt), 8'(16));
    drain();

    // Reset in the middle of DRIVE
    push(2'b10, 4'd5);
    push(2'b11, 4'd1);
    go();
    idle();
    idle();
    idle();
    cyc(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0);
    chk("midrst_jk", 8'({j, k}), 8'(0));
    chk("midrst_level", 8'(fifo_level), 8'(0));
    idle();

`ifdef JK_SEQ_ABORT_EN
    // Abort on the second DRIVE cycle of (11,5)
    push(2'b11, 4'd5);
    push(2'b10, 4'd0);
    go();
    idle();
    idle();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    chk("abort_jk", 8'({j, k}), 8'(1));
    chk("abort_level", 8'(fifo_level), 8'(0));
    idle();
    chk("abort_after_jk", 8'({j, k}), 8'(0));
    chk("abort_no_done", 8'(done), 8'(0));
    // Abort in IDLE only flushes
    push(2'b10, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    chk("abort_idle_level", 8'(fifo_level), 8'(0));
    idle();
`endif

    // Randomized traffic against the model
    saw_start = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, s, v, ab;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 12);
      v  = ($urandom_range(0, 99) < 45);
      ab = 1'b0;
`ifdef JK_SEQ_ABORT_EN
      ab = ($urandom_range(0, 99) < 3);
`endif
      if (s) saw_start++;
      cyc(r, s, v, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 4)), ab);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
